// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and runs mult/div as fixed-latency ops.
// Optional multiply-accumulate ops (9-12) are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] result,
  output logic        dbg_state
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  // How temp is folded into {HI,LO} when the operation completes.
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB, ACC_KEEP} acc_t;

  state_t        state_q, state_d;
  acc_t          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   temp_hi_q, temp_hi_d;
  logic [31:0]   temp_lo_q, temp_lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] quot_s, rem_s;
  logic [31:0] quot_u, rem_u;
  logic [63:0] hilo;
  logic [63:0] temp;

  // Sign-extended 64-bit multiply keeps the low 64 bits exact for signed operands.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};
  assign b_safe = (B == 32'b0) ? 32'd1 : B;

  always_comb begin
    quot_s = 32'($signed(A) / $signed(b_safe));
    rem_s  = 32'($signed(A) % $signed(b_safe));
    // INT_MIN / -1 overflows: architectural result is quotient INT_MIN, remainder 0.
    if (A == 32'h8000_0000 && b_safe == 32'hFFFF_FFFF) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'b0;
    end
  end

  assign quot_u = A / b_safe;
  assign rem_u  = A % b_safe;
  assign hilo   = {hi_q, lo_q};
  assign temp   = {temp_hi_q, temp_lo_q};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (op == OP_MULT || op == OP_MULTU)) begin
          {temp_hi_d, temp_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
          acc_d   = ACC_SET;
          cnt_d   = MULT_LOAD;
          state_d = S_BUSY;
        end else if (start && (op == OP_DIV || op == OP_DIVU)) begin
          temp_hi_d = (op == OP_DIV) ? rem_s  : rem_u;
          temp_lo_d = (op == OP_DIV) ? quot_s : quot_u;
          acc_d     = (B == 32'b0) ? ACC_KEEP : ACC_SET;
          cnt_d     = DIV_LOAD;
          state_d   = S_BUSY;
`ifdef MDU_MADD_EN
        end else if (start && (op == OP_MADD || op == OP_MADDU ||
                               op == OP_MSUB || op == OP_MSUBU)) begin
          {temp_hi_d, temp_lo_d} = (op == OP_MADD || op == OP_MSUB) ? prod_s : prod_u;
          acc_d   = (op == OP_MADD || op == OP_MADDU) ? ACC_ADD : ACC_SUB;
          cnt_d   = MULT_LOAD;
          state_d = S_BUSY;
`endif
        end else if (op == OP_MTHI) begin
          hi_d = A;
        end else if (op == OP_MTLO) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          unique case (acc_q)
            ACC_SET:  {hi_d, lo_d} = temp;
            ACC_ADD:  {hi_d, lo_d} = hilo + temp;
            ACC_SUB:  {hi_d, lo_d} = hilo - temp;
            ACC_KEEP: {hi_d, lo_d} = hilo;
            default:  {hi_d, lo_d} = hilo;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= ACC_SET;
      cnt_q     <= '0;
      hi_q      <= 32'b0;
      lo_q      <= 32'b0;
      temp_hi_q <= 32'b0;
      temp_lo_q <= 32'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign dbg_state = state_q;

  always_comb begin
    result = 32'b0;
    if (op == OP_MFHI) result = hi_q;
    else if (op == OP_MFLO) result = lo_q;
    else if (op == OP_NONE) result = 32'b0;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random mult/div traffic,
// with expected {HI,LO} pushed on launch and popped when busy drops.
module tb_mult_div_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = OP_NONE;
  logic [31:0] A = 32'b0;
  logic [31:0] B = 32'b0;
  logic        busy;
  logic [31:0] result;
  logic        dbg_state;

  logic [63:0] exp_q[$];
  logic [63:0] model_hilo = 64'b0;
  int          checks = 0;
  int          errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .result(result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    logic [31:0] ua, ub, q, r;
    logic [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      OP_MULT:  return sa * sb;
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return cur;
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        q = ua / ub;
        r = ua % ub;
        if (a[31] != b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      OP_DIVU:  return (b == 0) ? cur : {a % b, a / b};
`ifdef MDU_MADD_EN
      OP_MADD:  return cur + sa * sb;
      OP_MADDU: return cur + {32'b0, a} * {32'b0, b};
      OP_MSUB:  return cur - sa * sb;
      OP_MSUBU: return cur - {32'b0, a} * {32'b0, b};
`endif
      default:  return cur;
    endcase
  endfunction

  function automatic int cycles_of(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU: return 5;
      OP_DIV, OP_DIVU:   return 10;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  // Combinational HI/LO read through result; called mid-cycle while idle.
  task automatic read_hilo(output logic [63:0] v);
    op = OP_MFHI; #1; v[63:32] = result;
    op = OP_MFLO; #1; v[31:0]  = result;
    op = OP_NONE; #1;
  endtask

  task automatic write_hl(input logic [3:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    op = o; A = v;
    @(posedge clk); #1;
    op = OP_NONE; A = 32'b0;
    if (o == OP_MTHI) model_hilo[63:32] = v;
    else model_hilo[31:0] = v;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic interfere);
    logic [63:0] got, exp;
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b;
    model_hilo = model(o, a, b, model_hilo);
    exp_q.push_back(model_hilo);
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE; A = 32'b0; B = 32'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (interfere && n == 2) begin
        start = 1'b1; op = OP_MTHI; A = 32'hDEAD_BEEF;
      end else if (interfere && n == 3) begin
        start = 1'b0; op = OP_NONE; A = 32'b0;
      end
    end
    start = 1'b0; op = OP_NONE; A = 32'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(cycles_of(o)));
    read_hilo(got);
    exp = exp_q.pop_front();
    check(tag, got, exp);
  endtask

  initial begin
    logic [63:0] v;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    read_hilo(v);
    check("reset_hilo", v, 64'd0);

    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg3x5_const", model_hilo, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 1'b0);
    check("divu_7_2_const", model_hilo, {32'd1, 32'd3});
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7_2_const", model_hilo, 64'hFFFF_FFFF_FFFF_FFFD);

    write_hl(OP_MTHI, 32'd1234);
    write_hl(OP_MTLO, 32'd55);
    @(negedge clk);
    check("mt_busy", 64'(busy), 64'd0);
    op = OP_NONE; #1;
    check("result_none", 64'(result), 64'd0);
    run_op("div_by_zero", OP_DIV, 32'd100, 32'd0, 1'b0);
    check("div_by_zero_const", model_hilo, {32'd1234, 32'd55});

    run_op("mult_ignore_mthi", OP_MULT, 32'd6, 32'd7, 1'b1);
    run_op("divu_by_zero", OP_DIVU, 32'hFFFF_0000, 32'd0, 1'b0);

    // Reset mid-operation, with an MTLO arriving while busy.
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; A = 32'd11; B = 32'd13;
    @(posedge clk); #1;
    start = 1'b0; op = OP_MTLO; A = 32'd9;
    @(posedge clk); #1;
    op = OP_NONE; A = 32'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hilo = 64'b0;
    @(negedge clk);
    check("reset_mid_busy", 64'(busy), 64'd0);
    read_hilo(v);
    check("reset_mid_hilo", v, 64'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("reset_mid_stays_idle", 64'(busy), 64'd0);
    read_hilo(v);
    check("reset_mid_hilo_late", v, 64'd0);

    write_hl(OP_MTHI, 32'd0);
    write_hl(OP_MTLO, 32'd10);
    run_op("madd_2x3", OP_MADD, 32'd2, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    check("madd_2x3_const", model_hilo, 64'd16);
    run_op("msub_neg", OP_MSUB, 32'hFFFF_FFFF, 32'd4, 1'b0);
    run_op("maddu_big", OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("msubu_big", OP_MSUBU, 32'h8000_0000, 32'd2, 1'b0);
`else
    check("madd_2x3_const", model_hilo, 64'd10);
`endif

    run_op("div_min_neg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg_neg", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int k = 0; k < 12; k++) begin
      ro = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'b0 : $urandom;
      if (ro == OP_DIV || ro == OP_DIVU) rb = rb >> $urandom_range(0, 28);
      run_op($sformatf("rand_%0d_op%0d", k, ro), ro, ra, rb, 1'(k % 3 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
